// File: rtl/secam_fm_modulator.sv
// SECAM FM chroma subcarrier generator: alternating Db/Dr line deviation,
// phase accumulator and quarter-wave sine lookup, four-stage pipeline.
module secam_fm_modulator #(
  parameter int                    PHASE_BITS    = 24,
  parameter logic [PHASE_BITS-1:0] DB_CENTER_INC = PHASE_BITS'(6_990_506),
  parameter logic [PHASE_BITS-1:0] DR_CENTER_INC = PHASE_BITS'(7_247_531),
  parameter int                    DB_GAIN       = 1700,
  parameter int                    DR_GAIN       = -2200,
  parameter int                    DEV_SHIFT     = 2,
  parameter int                    DEV_LIMIT     = 200
) (
  input  logic              clk,
  input  logic              rst,
  input  logic signed [8:0] db,
  input  logic signed [8:0] dr,
  input  logic              frame_start,
  input  logic              line_start,
  input  logic              chroma_window,
  output logic signed [7:0] carrier,
  output logic              line_is_db
);

  localparam int              RND = (DEV_SHIFT > 0) ? (1 << (DEV_SHIFT - 1)) : 0;
  localparam logic signed [8:0] LIM = 9'(DEV_LIMIT);

  // First quadrant of 127*sin, sampled at bin centres so quadrants mirror cleanly.
  localparam logic [6:0] QTBL [64] = '{
    7'd2,   7'd5,   7'd8,   7'd11,  7'd14,  7'd17,  7'd20,  7'd23,
    7'd26,  7'd29,  7'd32,  7'd35,  7'd38,  7'd41,  7'd44,  7'd47,
    7'd50,  7'd53,  7'd56,  7'd58,  7'd61,  7'd64,  7'd67,  7'd69,
    7'd72,  7'd74,  7'd77,  7'd79,  7'd82,  7'd84,  7'd86,  7'd89,
    7'd91,  7'd93,  7'd95,  7'd97,  7'd99,  7'd101, 7'd103, 7'd105,
    7'd106, 7'd108, 7'd110, 7'd111, 7'd113, 7'd114, 7'd115, 7'd117,
    7'd118, 7'd119, 7'd120, 7'd121, 7'd122, 7'd123, 7'd124, 7'd124,
    7'd125, 7'd125, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127, 7'd127
  };

  logic signed [8:0]     sel_q;
  logic                  db_q;
  logic [PHASE_BITS-1:0] inc_q;
  logic [PHASE_BITS-1:0] phase_q;
  logic [2:0]            win_pipe;

  logic signed [8:0]  sel_raw, sel_clamp;
  logic signed [31:0] sel32, gain32, dev32, inc32;
  logic [7:0]         p;
  logic [5:0]         idx;
  logic [6:0]         mag;
  logic signed [7:0]  samp;

  always_comb begin
    sel_raw   = line_is_db ? db : dr;
    sel_clamp = sel_raw;
    if (sel_raw > LIM)       sel_clamp = LIM;
    else if (sel_raw < -LIM) sel_clamp = -LIM;
  end

  always_comb begin
    sel32  = {{23{sel_q[8]}}, sel_q};
    gain32 = db_q ? 32'(DB_GAIN) : 32'(DR_GAIN);
    dev32  = (gain32 * sel32 + 32'(RND)) >>> DEV_SHIFT;
    inc32  = (db_q ? 32'(DB_CENTER_INC) : 32'(DR_CENTER_INC)) + dev32;
  end

  // Odd quadrants read the table backwards, the lower half-wave is negated.
  always_comb begin
    p    = phase_q[PHASE_BITS-1 -: 8];
    idx  = p[6] ? ~p[5:0] : p[5:0];
    mag  = QTBL[idx];
    samp = p[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_is_db <= 1'b0;
      sel_q      <= '0;
      db_q       <= 1'b0;
      inc_q      <= '0;
      phase_q    <= '0;
      win_pipe   <= '0;
      carrier    <= '0;
    end else begin
      if (frame_start)     line_is_db <= 1'b0;
      else if (line_start) line_is_db <= ~line_is_db;
      sel_q    <= sel_clamp;
      db_q     <= line_is_db;
      inc_q    <= PHASE_BITS'(inc32);
      phase_q  <= line_start ? '0 : phase_q + inc_q;
      win_pipe <= {win_pipe[1:0], chroma_window};
      carrier  <= win_pipe[2] ? samp : '0;
    end
  end

endmodule

// File: tb/tb_secam_fm_modulator.sv
// Directed bench for secam_fm_modulator: reset, line alternation, deviation,
// rest frequency, sine table walk, window gating and mid-line reset.
module tb_secam_fm_modulator;

  localparam longint MASK   = (64'd1 << 24) - 1;
  localparam longint DB_C   = 6990506;
  localparam longint DR_C   = 7247531;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [8:0] db, dr;
  logic              frame_start, line_start, chroma_window;
  logic signed [7:0] carrier, carrier_t;
  logic              line_is_db, line_is_db_t;

  always #5 clk = ~clk;

  secam_fm_modulator dut (
    .clk(clk), .rst(rst), .db(db), .dr(dr), .frame_start(frame_start),
    .line_start(line_start), .chroma_window(chroma_window),
    .carrier(carrier), .line_is_db(line_is_db)
  );

  // Centre increment of exactly one table step per clock, for walking the sine table.
  secam_fm_modulator #(.DB_CENTER_INC(24'd65536), .DR_CENTER_INC(24'd65536)) dut_t (
    .clk(clk), .rst(rst), .db(db), .dr(dr), .frame_start(frame_start),
    .line_start(line_start), .chroma_window(chroma_window),
    .carrier(carrier_t), .line_is_db(line_is_db_t)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int sine_ref(input int k);
    real a;
    a = 2.0 * 3.14159265358979 * (real'(k) + 0.5) / 256.0;
    return int'(127.0 * $sin(a));
  endfunction

  typedef struct {
    logic fs;
    logic ls;
    logic exp_db;
  } alt_t;

  typedef struct {
    logic              is_db;
    logic signed [8:0] db;
    logic signed [8:0] dr;
    longint            exp_inc;
  } dev_t;

  alt_t   alt_v[10];
  dev_t   dev_v[11];
  longint p0, prev_ph, d;
  logic signed [7:0] prev_c;
  int     zc, bad_inc, bad_rng;

  initial begin
    alt_v = '{
      '{1'b1, 1'b0, 1'b0}, '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b0},
      '{1'b0, 1'b1, 1'b1}, '{1'b0, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1},
      '{1'b0, 1'b0, 1'b1}, '{1'b1, 1'b1, 1'b0}, '{1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0}
    };
    dev_v = '{
      '{1'b1,  9'sd255,    9'sd0,   DB_C + 85000},
      '{1'b1, -9'sd255,    9'sd0,   DB_C - 85000},
      '{1'b1,  9'sd200,    9'sd0,   DB_C + 85000},
      '{1'b1,  9'sd1,      9'sd0,   DB_C + 425},
      '{1'b1, -9'sd1,      9'sd0,   DB_C - 425},
      '{1'b1,  9'sd3,      9'sd0,   DB_C + 1275},
      '{1'b1,  9'sd0,      9'sd255, DB_C},
      '{1'b0,  9'sd0,     -9'sd255, DR_C + 110000},
      '{1'b0,  9'sd0,      9'sd255, DR_C - 110000},
      '{1'b0,  9'sd0,      9'sd7,   DR_C - 3850},
      '{1'b0,  9'sd255,    9'sd0,   DR_C}
    };

    rst = 1'b1; db = '0; dr = '0;
    frame_start = 1'b0; line_start = 1'b0; chroma_window = 1'b0;

    // Reset held with random stimulus
    for (int i = 0; i < 3; i++) begin
      db = 9'($urandom); dr = 9'($urandom);
      frame_start = 1'($urandom); line_start = 1'($urandom);
      chroma_window = 1'($urandom);
      tick();
      check("rst_carrier", carrier, 0);
      check("rst_line_is_db", line_is_db, 0);
    end
    rst = 1'b0; db = '0; dr = '0;
    frame_start = 1'b0; line_start = 1'b0; chroma_window = 1'b0;
    tick();
    check("post_rst_carrier", carrier, 0);
    check("post_rst_line_is_db", line_is_db, 0);

    // Line alternation table
    for (int i = 0; i < 10; i++) begin
      frame_start = alt_v[i].fs; line_start = alt_v[i].ls;
      tick();
      frame_start = 1'b0; line_start = 1'b0;
      check($sformatf("alt[%0d]", i), line_is_db, alt_v[i].exp_db);
    end

    // Deviation and clamp table
    for (int i = 0; i < 11; i++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      if (dev_v[i].is_db) begin
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
      end
      db = dev_v[i].db; dr = dev_v[i].dr;
      repeat (3) tick();
      check($sformatf("dev_inc[%0d]", i), dut.inc_q, dev_v[i].exp_inc);
    end

    // Rest carrier on a Db line
    db = '0; dr = '0; chroma_window = 1'b1;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    line_start = 1'b1;  tick(); line_start = 1'b0;
    repeat (6) tick();
    prev_ph = dut.phase_q; prev_c = carrier;
    zc = 0; bad_inc = 0; bad_rng = 0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      d = (longint'(dut.phase_q) - prev_ph) & MASK;
      if (d != DB_C) bad_inc++;
      if (carrier == 0 || carrier == -8'sd128) bad_rng++;
      if ((carrier < 0) != (prev_c < 0)) zc++;
      prev_ph = dut.phase_q; prev_c = carrier;
    end
    check("rest_phase_step_errors", bad_inc, 0);
    check("rest_range_errors", bad_rng, 0);
    // Two sign changes per carrier period: 2*10000*inc/2^24 ~ 8333, 0.1 % tolerance.
    check("rest_zero_crossings_in_tol", (zc >= 8325 && zc <= 8341) ? 1 : 0, 1);

    // Phase reset on line_start, then one table step per clock
    line_start = 1'b1; tick(); line_start = 1'b0;
    for (int j = 0; j < 260; j++) begin
      tick();
      check($sformatf("table_p%0d", j % 256), carrier_t, sine_ref(j % 256));
    end

    // Window gating, 7-cycle pulse on a Dr line
    chroma_window = 1'b0;
    frame_start = 1'b1; tick(); frame_start = 1'b0;
    repeat (6) tick();
    check("gate_idle_carrier", carrier, 0);
    p0 = dut.phase_q;
    for (int c = 0; c < 20; c++) begin
      chroma_window = (c < 7);
      tick();
      check($sformatf("gate_active[%0d]", c), (carrier != 0) ? 1 : 0,
            (c >= 3 && c <= 9) ? 1 : 0);
    end
    check("gate_phase_continuous", dut.phase_q, (p0 + 20 * DR_C) & MASK);

    // Reset in the middle of a Db line
    line_start = 1'b1; tick(); line_start = 1'b0;
    chroma_window = 1'b1;
    repeat (5) tick();
    check("pre_midrst_active", (carrier != 0) ? 1 : 0, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check("midrst_carrier", carrier, 0);
    check("midrst_line_is_db", line_is_db, 0);
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("midrst_active[%0d]", c), (carrier != 0) ? 1 : 0, (c >= 3) ? 1 : 0);
      check($sformatf("midrst_line[%0d]", c), line_is_db, 0);
    end
    line_start = 1'b1; tick(); line_start = 1'b0;
    check("midrst_next_line", line_is_db, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
